// File: rtl/irq_ctrl_if.sv
// Register-window bus between the bridge and the interrupt controller.
// The bridge drives address/strobes/data; the controller returns combinational read data.
interface irq_ctrl_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, output we, output be, output wd, input rd);
  modport slave  (input addr, input we, input be, input wd, output rd);
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: latches device requests, masks them and presents
// one pre-empting request to the core, tracking nesting through an in-service register.
module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int          N_SRC     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  irq_ctrl_if.slave        bus,
  input  logic             int_ack,
  input  logic             eret,
  output logic [N_SRC-1:0] hw_int
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [2:0] IDX_NONE = 3'(N_SRC);
  localparam logic [2:0] VEC_NONE = 3'd7;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] irq_prev_q;
  logic [N_SRC-1:0] hw_int_q, hw_int_d;
  logic [2:0]       vec_q, vec_d;

  logic [29:0]      word_off;
  logic             in_win, wr_en, wr_mask, wr_pend, wr_mode;
  logic [31:0]      rd_data;

  logic [N_SRC-1:0] cand, sel_onehot, isr_low, edge_set, ack_clr;
  logic [2:0]       sel_idx, top_idx, ack_idx;
  logic             eligible, ack_fire;
  logic             unused_bits;

  // Offset is computed by subtraction so addresses below the base wrap out of range.
  assign word_off = bus.addr[31:2] - BASE_ADDR[31:2];
  assign in_win   = (word_off < 30'd5);
  assign wr_en    = bus.we & bus.be[0] & in_win;
  assign wr_mask  = wr_en & (word_off == 30'd0);
  assign wr_pend  = wr_en & (word_off == 30'd1);
  assign wr_mode  = wr_en & (word_off == 30'd3);

  always_comb begin
    rd_data = '0;
    if (in_win) begin
      case (word_off[2:0])
        3'd0:    rd_data[N_SRC-1:0] = mask_q;
        3'd1:    rd_data[N_SRC-1:0] = pend_q;
        3'd2:    rd_data[N_SRC-1:0] = isr_q;
        3'd3:    rd_data[N_SRC-1:0] = mode_q;
        3'd4:    rd_data[2:0]       = vec_q;
        default: rd_data            = '0;
      endcase
    end
  end
  assign bus.rd = rd_data;

  assign unused_bits = ^{bus.be[3:1], bus.wd[31:N_SRC], bus.addr[1:0]};

  // Descending scan leaves the lowest set index in each result.
  assign cand = pend_q & mask_q & ~isr_q;
  always_comb begin
    sel_idx = IDX_NONE;
    top_idx = IDX_NONE;
    ack_idx = VEC_NONE;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i])     sel_idx = 3'(i);
      if (isr_q[i])    top_idx = 3'(i);
      if (hw_int_q[i]) ack_idx = 3'(i);
    end
  end

  assign eligible   = (sel_idx < top_idx);
  assign sel_onehot = eligible ? (N_SRC'(1) << sel_idx) : '0;

  // The acknowledged source is the one currently signalled on hw_int.
  assign ack_fire = int_ack & (state_q == REQ);
  assign ack_clr  = ack_fire ? hw_int_q : '0;
  assign isr_low  = isr_q & (~isr_q + N_SRC'(1));
  assign edge_set = irq_in & ~irq_prev_q & mode_q;

  assign isr_d  = (isr_q & ~(eret ? isr_low : '0)) | ack_clr;
  assign mask_d = wr_mask ? bus.wd[N_SRC-1:0] : mask_q;
  assign mode_d = wr_mode ? bus.wd[N_SRC-1:0] : mode_q;
  assign vec_d  = ack_fire ? ack_idx : vec_q;

  // Edge sources: clears first, then a new edge overrides them on the same bit.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
    assign pend_d[gi] = mode_q[gi]
                      ? ((pend_q[gi] & ~(wr_pend & bus.wd[gi]) & ~ack_clr[gi]) | edge_set[gi])
                      : irq_in[gi];
  end

  always_comb begin
    state_d  = state_q;
    hw_int_d = '0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d  = REQ;
          hw_int_d = sel_onehot;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
        end else if (eligible) begin
          hw_int_d = sel_onehot;
        end else begin
          state_d = IDLE;
        end
      end
      SERVICE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      pend_q     <= '0;
      isr_q      <= '0;
      mode_q     <= '0;
      irq_prev_q <= '0;
      hw_int_q   <= '0;
      vec_q      <= VEC_NONE;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      mode_q     <= mode_d;
      irq_prev_q <= irq_in;
      hw_int_q   <= hw_int_d;
      vec_q      <= vec_d;
    end
  end

  assign hw_int = hw_int_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: hand-computed vector table, directed nesting/reset sequences,
// and randomized traffic compared every cycle against a rule-level reference model.
module tb_irq_ctrl;
  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] irq_in;
  logic       int_ack;
  logic       eret;
  logic [5:0] hw_int;

  irq_ctrl_if bus();

  irq_ctrl #(.BASE_ADDR(BASE), .N_SRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus),
    .int_ack(int_ack),
    .eret   (eret),
    .hw_int (hw_int)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [5:0] m_mask, m_pend, m_isr, m_mode, m_prev, m_hw;
  logic [2:0] m_vec;
  logic       m_quiet;

  typedef struct packed {
    logic [5:0] irq;
    logic       wr;
    logic [2:0] woff;
    logic [5:0] wdata;
    logic       ack;
    logic       er;
    logic [5:0] exp_hw;
    logic [5:0] exp_pend;
    logic [5:0] exp_isr;
    logic [2:0] exp_vec;
  } row_t;

  row_t tbl [38];

  function automatic row_t mk(input logic [5:0] irq, input logic wr, input logic [2:0] woff,
                              input logic [5:0] wdata, input logic ack, input logic er,
                              input logic [5:0] exp_hw, input logic [5:0] exp_pend,
                              input logic [5:0] exp_isr, input logic [2:0] exp_vec);
    row_t r;
    r.irq = irq; r.wr = wr; r.woff = woff; r.wdata = wdata; r.ack = ack; r.er = er;
    r.exp_hw = exp_hw; r.exp_pend = exp_pend; r.exp_isr = exp_isr; r.exp_vec = exp_vec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_isr = '0; m_mode = '0; m_prev = '0; m_hw = '0;
    m_vec = 3'd7; m_quiet = 1'b0;
  endtask

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 6;
  endfunction

  function automatic logic [31:0] model_reg(input int off);
    case (off)
      0:       return {26'd0, m_mask};
      1:       return {26'd0, m_pend};
      2:       return {26'd0, m_isr};
      3:       return {26'd0, m_mode};
      default: return {29'd0, m_vec};
    endcase
  endfunction

  function automatic string reg_name(input int off);
    case (off)
      0:       return "rd_mask";
      1:       return "rd_pend";
      2:       return "rd_isr";
      3:       return "rd_mode";
      default: return "rd_vec";
    endcase
  endfunction

  // One clock of the rules: the request is the highest-priority pending, unmasked,
  // not-in-service source that beats everything in service; after an acknowledge the
  // line stays quiet for one extra cycle.
  task automatic model_step(input logic [5:0] irq, input logic wr, input logic [2:0] woff,
                            input logic [5:0] wdata, input logic ack, input logic er);
    logic [5:0] n_pend, n_isr, best;
    int         sel, top, src;
    logic       acked;
    sel   = lowest(m_pend & m_mask & ~m_isr);
    top   = lowest(m_isr);
    best  = (sel < top) ? 6'(1 << sel) : 6'd0;
    acked = ack && (m_hw != 0);
    src   = lowest(m_hw);
    n_isr = m_isr;
    if (er && m_isr != 0) n_isr[lowest(m_isr)] = 1'b0;
    if (acked) n_isr[src] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (!m_mode[i]) begin
        n_pend[i] = irq[i];
      end else begin
        n_pend[i] = m_pend[i];
        if (wr && woff == 3'd1 && wdata[i]) n_pend[i] = 1'b0;
        if (acked && src == i) n_pend[i] = 1'b0;
        if (irq[i] && !m_prev[i]) n_pend[i] = 1'b1;
      end
    end
    if (acked) m_vec = 3'(src);
    m_hw    = (m_quiet || acked) ? 6'd0 : best;
    m_quiet = acked;
    m_pend  = n_pend;
    m_isr   = n_isr;
    if (wr && woff == 3'd0) m_mask = wdata;
    if (wr && woff == 3'd3) m_mode = wdata;
    m_prev = irq;
  endtask

  task automatic read_reg(input int off, output logic [31:0] val);
    bus.addr = BASE + 32'(off * 4);
    #1;
    val = bus.rd;
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare every visible register.
  task automatic cycle(input logic [5:0] irq, input logic wr, input logic [2:0] woff,
                       input logic [5:0] wdata, input logic be0, input logic ack, input logic er);
    logic [31:0] v;
    irq_in   = irq;
    bus.we   = wr;
    bus.be   = {3'($urandom), be0};
    bus.addr = BASE + {27'd0, woff, 2'b00};
    bus.wd   = {26'($urandom), wdata};
    int_ack  = ack;
    eret     = er;
    model_step(irq, wr && be0 && (woff < 3'd5), woff, wdata, ack, er);
    @(posedge clk);
    #1;
    bus.we  = 1'b0;
    int_ack = 1'b0;
    eret    = 1'b0;
    chk("hw_int", {26'd0, hw_int}, {26'd0, m_hw});
    for (int k = 0; k < 5; k++) begin
      read_reg(k, v);
      chk(reg_name(k), v, model_reg(k));
    end
  endtask

  task automatic idle(input logic [5:0] irq);
    cycle(irq, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wreg(input logic [2:0] off, input logic [5:0] d);
    cycle(6'd0, 1'b1, off, d, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    logic [5:0]  r_irq;

    //         irq    wr  off   wdata  ack  er   hw     pend   isr    vec
    tbl[0]  = mk(6'h00, 1, 3'd3, 6'h3F, 0, 0, 6'h00, 6'h00, 6'h00, 3'd7);
    tbl[1]  = mk(6'h00, 1, 3'd0, 6'h01, 0, 0, 6'h00, 6'h00, 6'h00, 3'd7);
    tbl[2]  = mk(6'h01, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h01, 6'h00, 3'd7);
    tbl[3]  = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h01, 6'h01, 6'h00, 3'd7);
    tbl[4]  = mk(6'h00, 0, 3'd0, 6'h00, 1, 0, 6'h00, 6'h00, 6'h01, 3'd0);
    tbl[5]  = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h00, 6'h01, 3'd0);
    tbl[6]  = mk(6'h00, 0, 3'd0, 6'h00, 0, 1, 6'h00, 6'h00, 6'h00, 3'd0);
    tbl[7]  = mk(6'h00, 1, 3'd0, 6'h3F, 0, 0, 6'h00, 6'h00, 6'h00, 3'd0);
    tbl[8]  = mk(6'h0A, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h0A, 6'h00, 3'd0);
    tbl[9]  = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h02, 6'h0A, 6'h00, 3'd0);
    tbl[10] = mk(6'h00, 0, 3'd0, 6'h00, 1, 0, 6'h00, 6'h08, 6'h02, 3'd1);
    tbl[11] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h08, 6'h02, 3'd1);
    tbl[12] = mk(6'h00, 0, 3'd0, 6'h00, 0, 1, 6'h00, 6'h08, 6'h00, 3'd1);
    tbl[13] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h08, 6'h08, 6'h00, 3'd1);
    tbl[14] = mk(6'h00, 0, 3'd0, 6'h00, 1, 0, 6'h00, 6'h00, 6'h08, 3'd3);
    tbl[15] = mk(6'h00, 0, 3'd0, 6'h00, 0, 1, 6'h00, 6'h00, 6'h00, 3'd3);
    tbl[16] = mk(6'h00, 1, 3'd0, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 3'd3);
    tbl[17] = mk(6'h00, 1, 3'd3, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 3'd3);
    tbl[18] = mk(6'h01, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h01, 6'h00, 3'd3);
    tbl[19] = mk(6'h01, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h01, 6'h00, 3'd3);
    tbl[20] = mk(6'h01, 1, 3'd0, 6'h01, 0, 0, 6'h00, 6'h01, 6'h00, 3'd3);
    tbl[21] = mk(6'h01, 0, 3'd0, 6'h00, 0, 0, 6'h01, 6'h01, 6'h00, 3'd3);
    tbl[22] = mk(6'h01, 1, 3'd1, 6'h01, 0, 0, 6'h01, 6'h01, 6'h00, 3'd3);
    tbl[23] = mk(6'h01, 0, 3'd0, 6'h00, 1, 0, 6'h00, 6'h01, 6'h01, 3'd0);
    tbl[24] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h00, 6'h01, 3'd0);
    tbl[25] = mk(6'h00, 0, 3'd0, 6'h00, 0, 1, 6'h00, 6'h00, 6'h00, 3'd0);
    tbl[26] = mk(6'h00, 1, 3'd3, 6'h3F, 0, 0, 6'h00, 6'h00, 6'h00, 3'd0);
    tbl[27] = mk(6'h00, 1, 3'd0, 6'h04, 0, 0, 6'h00, 6'h00, 6'h00, 3'd0);
    tbl[28] = mk(6'h04, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h04, 6'h00, 3'd0);
    tbl[29] = mk(6'h00, 1, 3'd1, 6'h04, 0, 0, 6'h04, 6'h00, 6'h00, 3'd0);
    tbl[30] = mk(6'h04, 1, 3'd1, 6'h04, 0, 0, 6'h00, 6'h04, 6'h00, 3'd0);
    tbl[31] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h04, 6'h04, 6'h00, 3'd0);
    tbl[32] = mk(6'h04, 0, 3'd0, 6'h00, 1, 0, 6'h00, 6'h04, 6'h04, 3'd2);
    tbl[33] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h00, 6'h04, 6'h04, 3'd2);
    tbl[34] = mk(6'h00, 0, 3'd0, 6'h00, 0, 1, 6'h00, 6'h04, 6'h00, 3'd2);
    tbl[35] = mk(6'h00, 0, 3'd0, 6'h00, 0, 0, 6'h04, 6'h04, 6'h00, 3'd2);
    tbl[36] = mk(6'h00, 1, 3'd2, 6'h3F, 0, 0, 6'h04, 6'h04, 6'h00, 3'd2);
    tbl[37] = mk(6'h00, 1, 3'd4, 6'h00, 0, 0, 6'h04, 6'h04, 6'h00, 3'd2);

    reset    = 1'b0;
    irq_in   = '0;
    int_ack  = 1'b0;
    eret     = 1'b0;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.be   = '0;
    bus.wd   = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hw_int", {26'd0, hw_int}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      read_reg(k, v);
      chk({"reset_", reg_name(k)}, v, (k == 4) ? 32'd7 : 32'd0);
    end
    reset = 1'b1;

    // Hand-computed vectors: edge, priority, level/mask, collisions, ignored writes
    for (int i = 0; i < 38; i++) begin
      cycle(tbl[i].irq, tbl[i].wr, tbl[i].woff, tbl[i].wdata, 1'b1, tbl[i].ack, tbl[i].er);
      chk($sformatf("tbl%0d_hw", i), {26'd0, hw_int}, {26'd0, tbl[i].exp_hw});
      read_reg(1, v); chk($sformatf("tbl%0d_pend", i), v, {26'd0, tbl[i].exp_pend});
      read_reg(2, v); chk($sformatf("tbl%0d_isr", i), v, {26'd0, tbl[i].exp_isr});
      read_reg(4, v); chk($sformatf("tbl%0d_vec", i), v, {29'd0, tbl[i].exp_vec});
    end

    bus.addr = BASE + 32'h14;
    #1 chk("rd_past_window", bus.rd, 32'd0);
    bus.addr = BASE - 32'h4;
    #1 chk("rd_below_window", bus.rd, 32'd0);

    // Asynchronous reset while a request is being signalled
    reset = 1'b0;
    #1;
    chk("async_reset_hw", {26'd0, hw_int}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      read_reg(k, v);
      chk({"async_reset_", reg_name(k)}, v, (k == 4) ? 32'd7 : 32'd0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();

    // Nesting: source 4 in service, source 2 pre-empts, source 5 is blocked
    wreg(3'd3, 6'h3F);
    wreg(3'd0, 6'h3F);
    idle(6'h10);
    idle(6'h00);
    chk("nest_req4", {26'd0, hw_int}, 32'h10);
    cycle(6'h00, 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    read_reg(2, v); chk("nest_isr10", v, 32'h10);
    idle(6'h00);
    idle(6'h00);
    idle(6'h04);
    idle(6'h00);
    chk("nest_req2", {26'd0, hw_int}, 32'h04);
    cycle(6'h00, 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    read_reg(2, v); chk("nest_isr14", v, 32'h14);
    idle(6'h00);
    idle(6'h00);
    idle(6'h20);
    idle(6'h00);
    idle(6'h00);
    chk("nest_blocked5", {26'd0, hw_int}, 32'h0);
    cycle(6'h00, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    read_reg(2, v); chk("nest_eret1", v, 32'h10);
    cycle(6'h00, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b1);
    read_reg(2, v); chk("nest_eret2", v, 32'h00);

    // Randomized traffic against the reference model
    r_irq = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) r_irq = 6'($urandom);
      cycle(r_irq,
            ($urandom_range(0, 5) == 0),
            3'($urandom_range(0, 7)),
            6'($urandom),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
